// File: rtl/code_sender_pkg.sv
// Shared symbol encodings, the code table and FSM state type for code_sender.
package code_sender_pkg;

  // {left, right} drive patterns
  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_LEFT  = 2'b10;
  localparam logic [1:0] SYM_RIGHT = 2'b01;

  // Code table, symbol 0 in the least-significant pair
  localparam logic [15:0] CODE_TABLE = {SYM_IDLE, SYM_LEFT, SYM_IDLE, SYM_RIGHT,
                                        SYM_IDLE, SYM_LEFT, SYM_IDLE, SYM_LEFT};

  // Symbol index that carries the deliberate fault when err_inject is latched
  localparam logic [2:0] ERR_SYM_IDX = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDone
  } state_e;

  // Drive pattern for a symbol index, with the optional injected fault
  function automatic logic [1:0] code_sym(input logic [2:0] idx, input logic err);
    logic [1:0] sym;
    sym = CODE_TABLE[{idx, 1'b0} +: 2];
    if (err && (idx == ERR_SYM_IDX)) begin
      sym = SYM_LEFT;
    end
    return sym;
  endfunction

endpackage

// File: rtl/code_sender_hold_timer.sv
// Per-symbol hold counter: load a count, decrement to zero, flag the last cycle.
module hold_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final cycle of the loaded hold period
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/code_sender.sv
// Plays an 8-symbol left/right button code, optionally repeated, with abort.
module code_sender
  import code_sender_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] reps,
  input  logic       err_inject,
  input  logic       abort,
  output logic       left,
  output logic       right,
  output logic       busy,
  output logic       done,
  output logic [2:0] sym_idx
);

  localparam logic [CNT_W-1:0] HoldVal = CNT_W'(HOLD_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] sym_idx_q, sym_idx_d;
  logic [1:0] reps_q, reps_d;
  logic       err_q, err_d;
  logic       left_q, left_d;
  logic       right_q, right_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire;

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_expire)
  );

  // Next state, symbol sequencing and registered-output values
  always_comb begin
    state_d   = state_q;
    sym_idx_d = sym_idx_q;
    reps_d    = reps_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_val   = HoldVal;

    unique case (state_q)
      StIdle: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          state_d   = StPlay;
          sym_idx_d = 3'd0;
          reps_d    = reps;
          err_d     = err_inject;
          tmr_load  = 1'b1;
        end
      end
      StPlay: begin
        if (abort) begin
          state_d   = StIdle;
          sym_idx_d = 3'd0;
          tmr_load  = 1'b1;
          tmr_val   = '0;
        end else if (tmr_expire) begin
          if (sym_idx_q != 3'd7) begin
            sym_idx_d = sym_idx_q + 3'd1;
            tmr_load  = 1'b1;
          end else if (reps_q != 2'd0) begin
            sym_idx_d = 3'd0;
            reps_d    = reps_q - 2'd1;
            tmr_load  = 1'b1;
          end else begin
            state_d   = StDone;
            sym_idx_d = 3'd0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        sym_idx_d = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered
    busy_d            = (state_d == StPlay);
    done_d            = (state_d == StDone);
    {left_d, right_d} = busy_d ? code_sym(sym_idx_d, err_d) : SYM_IDLE;
  end

  // State and output registers; reset outranks abort and start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sym_idx_q <= 3'd0;
      reps_q    <= 2'd0;
      err_q     <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_idx_q <= sym_idx_d;
      reps_q    <= reps_d;
      err_q     <= err_d;
      left_q    <= left_d;
      right_q   <= right_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign left    = left_q;
  assign right   = right_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sym_idx = sym_idx_q;

endmodule

// File: tb/tb_code_sender.sv
// Self-checking bench for code_sender against a cycle-indexed playback model.
module tb_code_sender;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] reps = 2'd0;
  logic       err_inject = 1'b0;
  logic       abort = 1'b0;
  logic       left, right, busy, done;
  logic [2:0] sym_idx;

  int n_chk  = 0;
  int n_fail = 0;

  code_sender #(
    .HOLD_CYCLES(H),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reps      (reps),
    .err_inject(err_inject),
    .abort     (abort),
    .left      (left),
    .right     (right),
    .busy      (busy),
    .done      (done),
    .sym_idx   (sym_idx)
  );

  always #5 clk = ~clk;

  // Code table as written in the requirements, {left,right} per symbol
  logic [1:0] code_tbl [8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

  // Receiver model: two-stage debounce, then run-length decode of symbols.
  // A frame is recognised when symbols 0..6 each last about H cycles in order.
  localparam logic [13:0] FRAME = 14'b10_00_10_00_01_00_10;
  logic [1:0]  deb1 = 2'b00, deb2 = 2'b00, cur = 2'b00;
  logic [13:0] hist = '1;
  int          run_len = 0;
  int          led_cnt = 0;
  logic [1:0]  run_sym;

  always_comb run_sym = ((run_len >= H - 1) && (run_len <= H + 1)) ? cur : 2'b11;

  always @(posedge clk) begin
    deb1 <= {left, right};
    deb2 <= deb1;
    if (deb2 == cur) begin
      run_len <= run_len + 1;
    end else begin
      hist <= {hist[11:0], run_sym};
      if ({hist[11:0], run_sym} == FRAME) led_cnt <= led_cnt + 1;
      cur     <= deb2;
      run_len <= 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One playback from a start edge. cut_abort / cut_rst: cycle in which abort or
  // rst is driven (0 = never). extra_start: cycle in which start is re-pulsed.
  task automatic play(input int r, input bit e, input int cut_abort, input int cut_rst,
                      input int extra_start, input bit rnd_start, input string name);
    int         total;
    int         cut;
    int         last;
    int         led0;
    int         sym;
    bit         stopped;
    logic [6:0] expv;
    total = 8 * H * (r + 1);
    cut   = (cut_abort > 0) ? cut_abort : cut_rst;
    last  = (cut > 0) ? cut + 4 : total + 1;
    led0  = led_cnt;
    start = 1'b1;
    reps  = 2'(r);
    err_inject = e;
    tick();
    start = 1'b0;
    reps  = 2'($urandom);
    err_inject = 1'($urandom);
    for (int c = 1; c <= last; c++) begin
      stopped = (cut > 0) && (c > cut);
      if (stopped) begin
        expv = 7'b0;
      end else if (c <= total) begin
        sym  = ((c - 1) % (8 * H)) / H;
        expv = {(e && sym == 4) ? 2'b10 : code_tbl[sym], 2'b10, 3'(sym)};
      end else begin
        expv = {2'b00, 2'b01, 3'd0};
      end
      chk($sformatf("%s c%0d {l,r,busy,done,idx}", name, c),
          32'({left, right, busy, done, sym_idx}), 32'(expv));
      abort = (c == cut_abort);
      rst   = (c == cut_rst);
      if (stopped || c > total + 1) start = 1'b0;
      else if (rnd_start) start = 1'($urandom);
      else start = (c == extra_start);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    chk($sformatf("%s idle after", name), 32'({left, right, busy, done, sym_idx}), 32'd0);
    if (cut == 0) begin
      chk($sformatf("%s led frames", name), 32'(led_cnt - led0), e ? 32'd0 : 32'(r + 1));
    end
  endtask

  initial begin
    int r;
    int ab;
    bit e;

    // Reset state
    rst = 1'b1;
    tick();
    chk("reset outputs", 32'({left, right, busy, done, sym_idx}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle after reset", 32'({left, right, busy, done, sym_idx}), 32'd0);

    // Basic single frame, then repeated frames, then injected fault
    play(0, 1'b0, 0, 0, 0, 1'b0, "basic");
    play(2, 1'b0, 0, 0, 0, 1'b0, "reps2");
    play(0, 1'b1, 0, 0, 0, 1'b0, "errinj");
    play(3, 1'b1, 0, 0, 0, 1'b0, "errinj_reps3");

    // Abort mid-playback, then a fresh start must be accepted
    play(0, 1'b0, 20, 0, 0, 1'b0, "abort20");
    play(0, 1'b0, 0, 0, 0, 1'b0, "after_abort");

    // Reset mid-playback with an ignored start at cycle 10
    play(1, 1'b0, 0, 30, 10, 1'b0, "rst30");

    // Abort beats start in idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_vs_start", 32'({left, right, busy, done, sym_idx}), 32'd0);
    tick();
    chk("abort_vs_start hold", 32'({left, right, busy, done, sym_idx}), 32'd0);

    // Randomized playbacks with start noise while busy and occasional abort
    for (int i = 0; i < 6; i++) begin
      r  = $urandom_range(0, 3);
      e  = 1'($urandom_range(0, 1));
      ab = (i % 2 == 1) ? $urandom_range(1, 8 * H * (r + 1)) : 0;
      play(r, e, ab, 0, 0, 1'b1, $sformatf("rand%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/code_sender.md
CODE_SENDER -- requirements
Module: code_sender

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8, meaning clocks each symbol is held (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the hold counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to play the code; sampled only in IDLE.
REQ-006 SHALL have port reps  input  2  repetition count; the code plays reps+1 times; sampled with start.
REQ-007 SHALL have port err_inject  input  1  when high at start, symbol 4 becomes LEFT, producing a deliberately wrong code.
REQ-008 SHALL have port abort  input  1  terminates playback immediately.
REQ-009 SHALL have port left  output  1  left-button drive.
REQ-010 SHALL have port right  output  1  right-button drive.
REQ-011 SHALL have port busy  output  1  high while symbols are being played.
REQ-012 SHALL have port done  output  1  one-cycle pulse when playback completes normally.
REQ-013 SHALL have port sym_idx  output  3  index of the symbol currently driven; 0 when idle.

Function
REQ-014 SHALL play the code table {left,right}: 0=10, 1=00, 2=10, 3=00, 4=01, 5=00, 6=10, 7=00.
REQ-015 SHALL implement the FSM states IDLE, PLAY and DONE.
REQ-016 SHALL, in IDLE with start=1, latch reps and err_inject and enter PLAY; in the next cycle busy=1, sym_idx=0 and {left,right}=10.
REQ-017 SHALL hold each symbol for exactly HOLD_CYCLES cycles, then advance sym_idx by 1.
REQ-018 SHALL, after symbol 7, wrap to symbol 0 and decrement the latched repetition count if it is nonzero; otherwise enter DONE.
REQ-019 SHALL, in DONE, assert done=1, busy=0 and {left,right}=00 for one cycle, then return to IDLE.
REQ-020 SHALL ensure left and right are never high in the same cycle.
REQ-021 SHALL drive {left,right}=00 and sym_idx=0 in IDLE and DONE.
REQ-022 SHALL ignore start while busy=1 or in DONE; no re-trigger and no queuing.
REQ-023 SHALL, on abort=1 in PLAY, enter IDLE next cycle with outputs 00, busy=0 and no done pulse.
REQ-024 SHALL give abort priority over start when both are asserted in the same cycle in IDLE (stay IDLE).
REQ-025 SHALL apply err_inject to symbol 4 in every repetition of that playback.
REQ-026 SHALL have a total playback length of 8*HOLD_CYCLES*(reps+1) busy cycles, followed by one done cycle.
REQ-027 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE with left=0, right=0, busy=0, done=0, sym_idx=0, hold counter=0 and latched reps/err_inject=0.
REQ-029 SHALL, when rst is asserted mid-playback, abandon playback with no done pulse; rst has priority over abort and start.

Structure
REQ-030 SHALL place in a shared package: symbol constants SYM_IDLE=00, SYM_LEFT=10, SYM_RIGHT=01; the 8-entry code table; and the FSM state encoding.
REQ-031 SHALL place the per-symbol hold count in one sub-module, hold_timer (load, count down, expire pulse).

Verification
REQ-032 SHALL verify: HOLD=8, reps=0, start at cycle 0 -> left high cycles 1-8, 17-24 and 49-56; right high 33-40; busy 1-64; done at cycle 65 only.
REQ-033 SHALL verify: reps=2 -> 192 busy cycles with three identical code frames and a single done pulse.
REQ-034 SHALL verify: err_inject=1 -> cycles 33-40 drive left=1, right=0, and right is never high during playback.
REQ-035 SHALL verify: abort at cycle 20 -> cycle 21 outputs 00 and busy=0, done is never asserted, and a new start is then accepted.
REQ-036 SHALL verify: rst pulse at cycle 30 with start held high at cycle 10 -> all outputs 0 from cycle 31, and start at cycle 10 is ignored.
REQ-037 SHALL verify end-to-end: code_sender -> debounce x2 -> detector with HOLD=8 -> exactly one led_out per frame; err_inject=1 -> no led_out.
